// File: rtl/sram_ctl.sv
// rtl/sram_ctl.sv - Responder for the 16-bit RAM request/ack bus driving an async 16-bit SRAM.
// One request at a time; read/write strobes timed by RD_WAIT/WR_WAIT wait states.
module sram_ctl #(
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_req,
  input  logic [17:0] ram_addr,
  input  logic [15:0] ram_wdata,
  input  logic [1:0]  ram_wstrb,
  input  logic        ram_we,
  output logic        ram_ack,
  output logic [15:0] ram_rdata,
  output logic [17:0] sram_a,
  output logic [15:0] sram_dq_o,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_i,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_lb_n,
  output logic        sram_ub_n,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD
  } state_t;

  localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WR_WAIT - 1);

  state_t      r_state;
  state_t      w_state_nx;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nx;
  logic [1:0]  r_wstrb;
  logic [1:0]  w_strb_src;
  logic        w_accept;
  logic        w_rd_done;
  logic        w_wr_done;
  logic        w_ce_n_nx;
  logic        w_oe_n_nx;
  logic        w_we_n_nx;
  logic        w_lb_n_nx;
  logic        w_ub_n_nx;
  logic        w_dq_oe_nx;

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_accept   = 1'b0;
    w_rd_done  = 1'b0;
    w_wr_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ram_req) begin
          w_accept = 1'b1;
          if (ram_we) begin
            w_state_nx = S_WR_SETUP;
          end else begin
            w_state_nx = S_RD;
            w_cnt_nx   = RD_LOAD;
          end
        end
      end
      S_RD: begin
        if (r_cnt == 4'd0) begin
          w_state_nx = S_IDLE;
          w_rd_done  = 1'b1;
        end else begin
          w_cnt_nx = r_cnt - 4'd1;
        end
      end
      S_WR_SETUP: begin
        w_state_nx = S_WR_PULSE;
        w_cnt_nx   = WR_LOAD;
      end
      S_WR_PULSE: begin
        if (r_cnt == 4'd0) begin
          w_state_nx = S_WR_HOLD;
        end else begin
          w_cnt_nx = r_cnt - 4'd1;
        end
      end
      S_WR_HOLD: begin
        w_state_nx = S_IDLE;
        w_wr_done  = 1'b1;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state, so a write being accepted
  // this cycle must take its byte enables straight from the request.
  assign w_strb_src = w_accept ? ram_wstrb : r_wstrb;

  always_comb begin
    w_ce_n_nx  = 1'b1;
    w_oe_n_nx  = 1'b1;
    w_we_n_nx  = 1'b1;
    w_lb_n_nx  = 1'b1;
    w_ub_n_nx  = 1'b1;
    w_dq_oe_nx = 1'b0;
    case (w_state_nx)
      S_RD: begin
        w_ce_n_nx = 1'b0;
        w_oe_n_nx = 1'b0;
        w_lb_n_nx = 1'b0;
        w_ub_n_nx = 1'b0;
      end
      S_WR_SETUP, S_WR_PULSE, S_WR_HOLD: begin
        w_ce_n_nx  = 1'b0;
        w_dq_oe_nx = 1'b1;
        w_lb_n_nx  = ~w_strb_src[0];
        w_ub_n_nx  = ~w_strb_src[1];
        w_we_n_nx  = (w_state_nx != S_WR_PULSE);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_wstrb    <= 2'b00;
      sram_a     <= 18'd0;
      sram_dq_o  <= 16'd0;
      ram_rdata  <= 16'd0;
      ram_ack    <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_lb_n  <= 1'b1;
      sram_ub_n  <= 1'b1;
      sram_dq_oe <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      ram_ack    <= w_rd_done | w_wr_done;
      sram_ce_n  <= w_ce_n_nx;
      sram_oe_n  <= w_oe_n_nx;
      sram_we_n  <= w_we_n_nx;
      sram_lb_n  <= w_lb_n_nx;
      sram_ub_n  <= w_ub_n_nx;
      sram_dq_oe <= w_dq_oe_nx;
      busy       <= (w_state_nx != S_IDLE);
      if (w_accept) begin
        sram_a    <= ram_addr;
        sram_dq_o <= ram_wdata;
        r_wstrb   <= ram_wstrb;
      end
      if (w_rd_done) begin
        ram_rdata <= sram_dq_i;
      end
      // A request that arrives while an access is in flight is dropped.
      if (ram_req && (r_state != S_IDLE)) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/sram_ctl.md
Name: sram_ctl

Overview:
- Responder end of the 16-bit RAM request/ack bus; drives an external asynchronous 16-bit SRAM.
- Accepts one single-cycle request at a time and services it with programmable wait states.
- Answers with a single-cycle ack, plus read data on reads.
- Sits below the RAM arbiter; its ram_* ports connect 1:1 to the arbiter's ram_* ports.

Parameters:
- RD_WAIT, 2, cycles oe_n is held low before read data is sampled (legal range 1..15).
- WR_WAIT, 2, cycles we_n is held low per write (legal range 1..15).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- ram_req  in  1  single-cycle request strobe
- ram_addr  in  18  word address, valid in the ram_req cycle
- ram_wdata  in  16  write data, valid in the ram_req cycle
- ram_wstrb  in  2  byte enables; bit1 = upper byte, bit0 = lower byte
- ram_we  in  1  1 = write, 0 = read
- ram_ack  out  1  single-cycle completion strobe
- ram_rdata  out  16  read data, valid in the ram_ack cycle of a read
- sram_a  out  18  SRAM address
- sram_dq_o  out  16  SRAM data out
- sram_dq_oe  out  1  data bus output enable; the top level builds the tristate
- sram_dq_i  in  16  SRAM data in
- sram_ce_n  out  1  chip enable, active low
- sram_oe_n  out  1  output enable, active low
- sram_we_n  out  1  write enable, active low
- sram_lb_n  out  1  lower byte enable, active low
- sram_ub_n  out  1  upper byte enable, active low
- busy  out  1  high whenever state != IDLE
- err  out  1  sticky; set when ram_req arrives while busy

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst is synchronous and active-high; it takes priority over every other input.
- Reset values:
  - sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n = 1.
  - sram_dq_oe, ram_ack, busy, err = 0.
  - sram_a, sram_dq_o, ram_rdata = 0.
  - State = IDLE.
- Outputs: all registered, no combinational input-to-output paths.
- Request capture: in IDLE with ram_req=1, latch ram_addr, ram_wdata, ram_wstrb and ram_we. Inputs are ignored in every other cycle.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD; 4-bit wait counter.
- Read (request sampled in cycle T):
  - Cycles T+1..T+RD_WAIT: state RD; sram_a = latched address; ce_n = oe_n = lb_n = ub_n = 0; dq_oe = 0.
  - On the edge ending T+RD_WAIT: ram_rdata <= sram_dq_i, ram_ack <= 1, state -> IDLE.
  - ram_ack is high in T+RD_WAIT+1; read latency is RD_WAIT+1.
- Write (request sampled in cycle T):
  - T+1 WR_SETUP: ce_n = 0; dq_oe = 1; we_n = 1; lb_n = !wstrb[0], ub_n = !wstrb[1].
  - T+2..T+1+WR_WAIT WR_PULSE: as WR_SETUP, with we_n = 0.
  - T+2+WR_WAIT WR_HOLD: we_n = 1; ce_n, dq_oe and data still driven.
  - On the edge ending WR_HOLD: ram_ack <= 1, state -> IDLE.
  - Write latency is WR_WAIT+3.
  - sram_a and sram_dq_o stay stable from WR_SETUP through WR_HOLD.
- Bus signals outside an access:
  - oe_n is 1 during all write states.
  - In IDLE: ce_n, oe_n, we_n, lb_n and ub_n are all 1; dq_oe = 0.
  - sram_a and sram_dq_o hold their last values in IDLE.
- wstrb = 00 on a write: full write sequence runs with lb_n = ub_n = 1 (no byte written); ack is still issued.
- ram_rdata: changes only on read completion; held otherwise, including across writes.
- Back-to-back requests: ram_req is accepted in the same cycle ram_ack is high (state is already IDLE).
- ram_req while busy: request dropped, no ack for it, err <= 1. err is cleared only by rst.
- ram_ack: exactly one cycle per accepted request; never high in two consecutive cycles for one request.
- Reset mid-operation: next cycle is IDLE with reset values; no ack is issued for the aborted request; the bus is released (dq_oe = 0, all strobes high).

Test Plan:
- Read: RD_WAIT=2, SRAM model returns 16'hBEEF at 18'h00123; ram_req in cycle 0 -> oe_n low in cycles 1-2, ram_ack high only in cycle 3, ram_rdata = BEEF.
- Write: WR_WAIT=2, addr 18'h3FFFF, wdata 16'hA55A, wstrb 10 -> we_n low in cycles 2-3, ub_n=0, lb_n=1, dq_oe high in cycles 1-4; ack in cycle 5; model upper byte = A5, lower byte unchanged.
- Back-to-back: write then a read issued in the write's ack cycle -> both acked; read returns the written data; err stays 0.
- Busy violation: second ram_req during RD -> dropped; exactly one ack; err=1 and stays 1 until rst.
- Reset mid-write: rst during WR_PULSE -> next cycle we_n=1, ce_n=1, dq_oe=0, busy=0; no ack issued afterwards.
- wstrb=00 write followed by a read of the same address -> original data returned; ack issued for both.
